// File: rtl/fsmc_mem_bridge.sv
// fsmc_mem_bridge: FSMC (NAND-style, ALE/CLE) slave exposing a windowed RAM
// to the MCU, with a second FPGA-side read port and a host-write notify strobe.
//
// Ports:
//   clk, reset_l        system clock, synchronous active-low reset
//   ncs, noe, nwe       FSMC chip select / output enable / write enable (low)
//   ale, cle            address / command latch enables
//   data_i              bus data from the pad
//   data_o, data_oe     registered bus read data, pad drive enable
//   index_o             current bus pointer
//   usr_addr, usr_rdata FPGA-side read port (1-cycle latency, read-before-write)
//   host_wr, host_wr_addr  one-cycle pulse and address of each host data write
module fsmc_mem_bridge #(
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 9,
  parameter int unsigned SYNC = 3
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          ncs,
  input  logic          noe,
  input  logic          nwe,
  input  logic          ale,
  input  logic          cle,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          data_oe,
  output logic [AW-1:0] index_o,
  input  logic [AW-1:0] usr_addr,
  output logic [DW-1:0] usr_rdata,
  output logic          host_wr,
  output logic [AW-1:0] host_wr_addr
);

  localparam int unsigned DEPTH = 2**AW;

  localparam logic [7:0] CMD_INC_ON  = 8'h00;
  localparam logic [7:0] CMD_INC_OFF = 8'h01;
  localparam logic [7:0] CMD_STATUS  = 8'h70;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  logic [DW-1:0]   r_mem [DEPTH];

  logic [SYNC-1:0] r_noe_sync;
  logic [SYNC-1:0] r_nwe_sync;
  logic [AW-1:0]   r_index;
  logic            r_auto_inc;
  logic            r_stat_pend;
  logic            r_wrap;
  logic [DW-1:0]   r_data_o;
  logic [DW-1:0]   r_usr_rdata;
  logic            r_host_wr;
  logic [AW-1:0]   r_host_wr_addr;

  logic            w_rd_ev;
  logic            w_wr_ev;
  logic            w_wr_addr;
  logic            w_wr_cmd;
  logic            w_wr_data;
  logic            w_rd;
  logic            w_advance;
  logic [AW-1:0]   w_index_inc;
  logic [DW-1:0]   w_status;
  logic [7:0]      w_cmd;

  // Edge detection on the two oldest synchroniser bits, qualified by select.
  // Reset gating discards any edge seen in the reset cycle itself.
  assign w_rd_ev = reset_l & ~ncs &  r_noe_sync[SYNC-1] & ~r_noe_sync[SYNC-2];
  assign w_wr_ev = reset_l & ~ncs & ~r_nwe_sync[SYNC-1] &  r_nwe_sync[SYNC-2];

  // Event decode: ale > cle > data; a read colliding with a write is dropped.
  always_comb begin
    w_wr_addr   = w_wr_ev & ale;
    w_wr_cmd    = w_wr_ev & ~ale & cle;
    w_wr_data   = w_wr_ev & ~ale & ~cle;
    w_rd        = w_rd_ev & ~w_wr_ev;
    w_advance   = r_auto_inc & (w_wr_data | (w_rd & ~r_stat_pend));
    w_index_inc = r_index + AW'(1);
    w_status    = DW'({r_index, r_wrap, r_auto_inc});
    w_cmd       = data_i[7:0];
  end

  // Host write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_data) begin
      r_mem[r_index] <= data_i;
    end
  end

  // FPGA-side read port; a same-cycle host write is not visible until next cycle.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_usr_rdata <= '0;
    end else begin
      r_usr_rdata <= r_mem[usr_addr];
    end
  end

  // Synchronisers, pointer, command state and bus read data.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_noe_sync     <= '1;
      r_nwe_sync     <= '1;
      r_index        <= '0;
      r_auto_inc     <= 1'b1;
      r_stat_pend    <= 1'b0;
      r_wrap         <= 1'b0;
      r_data_o       <= '0;
      r_host_wr      <= 1'b0;
      r_host_wr_addr <= '0;
    end else begin
      r_noe_sync <= {r_noe_sync[SYNC-2:0], noe};
      r_nwe_sync <= {r_nwe_sync[SYNC-2:0], nwe};
      r_host_wr  <= w_wr_data;

      if (w_wr_data) begin
        r_host_wr_addr <= r_index;
      end

      if (w_wr_addr) begin
        r_index <= data_i[AW-1:0];
      end else if (w_wr_cmd) begin
        case (w_cmd)
          CMD_INC_ON:  r_auto_inc  <= 1'b1;
          CMD_INC_OFF: r_auto_inc  <= 1'b0;
          CMD_STATUS:  r_stat_pend <= 1'b1;
          CMD_RESET: begin
            r_index     <= '0;
            r_wrap      <= 1'b0;
            r_stat_pend <= 1'b0;
            r_auto_inc  <= 1'b1;
          end
          default: ;
        endcase
      end else if (w_advance) begin
        r_index <= w_index_inc;
        if (r_index == '1) begin
          r_wrap <= 1'b1;
        end
      end

      // A status read consumes the pending request and the sticky wrap flag.
      if (w_rd) begin
        if (r_stat_pend) begin
          r_data_o    <= w_status;
          r_stat_pend <= 1'b0;
          r_wrap      <= 1'b0;
        end else begin
          r_data_o <= r_mem[r_index];
        end
      end
    end
  end

  assign data_oe      = ~noe & ~ncs;
  assign data_o       = r_data_o;
  assign index_o      = r_index;
  assign usr_rdata    = r_usr_rdata;
  assign host_wr      = r_host_wr;
  assign host_wr_addr = r_host_wr_addr;

endmodule

// File: tb/tb_fsmc_mem_bridge.sv
// Scoreboarded bench for fsmc_mem_bridge: bus stimulus tasks update a
// behavioural model and queue expectations; monitors compare DUT responses.
module tb_fsmc_mem_bridge;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 9;
  localparam int unsigned DEPTH = 512;

  logic          clk;
  logic          reset_l;
  logic          ncs, noe, nwe, ale, cle;
  logic [DW-1:0] data_i;
  logic [DW-1:0] data_o;
  logic          data_oe;
  logic [AW-1:0] index_o;
  logic [AW-1:0] usr_addr;
  logic [DW-1:0] usr_rdata;
  logic          host_wr;
  logic [AW-1:0] host_wr_addr;

  fsmc_mem_bridge #(.DW(DW), .AW(AW), .SYNC(3)) dut (
    .clk(clk), .reset_l(reset_l), .ncs(ncs), .noe(noe), .nwe(nwe),
    .ale(ale), .cle(cle), .data_i(data_i), .data_o(data_o), .data_oe(data_oe),
    .index_o(index_o), .usr_addr(usr_addr), .usr_rdata(usr_rdata),
    .host_wr(host_wr), .host_wr_addr(host_wr_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] data;
    logic [8:0]  idx;
  } rd_exp_t;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
    logic [15:0] old;
    bit          chk_usr;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit mon_rd_en = 1'b1;

  // Reference model state
  logic [15:0] m_mem [DEPTH];
  int unsigned m_idx;
  bit          m_auto, m_stat, m_wrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_auto = 1; m_stat = 0; m_wrap = 0;
  endtask

  task automatic model_advance();
    if (m_idx == DEPTH - 1) m_wrap = 1;
    m_idx = (m_idx + 1) % DEPTH;
  endtask

  // One nwe strobe with the given latch enables and data
  task automatic bus_wr(input logic a, input logic c, input logic [15:0] d);
    @(negedge clk);
    ncs = 0; ale = a; cle = c; data_i = d; nwe = 0;
    repeat (3) @(negedge clk);
    nwe = 1;
    repeat (4) @(negedge clk);
    ale = 0; cle = 0; ncs = 1;
  endtask

  // One noe strobe; the read monitor samples on noe's rising edge
  task automatic bus_rd();
    @(negedge clk);
    ncs = 0; noe = 0;
    repeat (6) @(negedge clk);
    check("data_oe_during_read", 32'(data_oe), 32'd1);
    noe = 1;
    @(negedge clk);
    ncs = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic op_addr(input logic [15:0] d);
    m_idx = d % DEPTH;
    bus_wr(1'b1, 1'b0, d);
  endtask

  task automatic op_cmd(input logic [7:0] c);
    logic [7:0] hi;
    hi = 8'($urandom);
    case (c)
      8'h00: m_auto = 1;
      8'h01: m_auto = 0;
      8'h70: m_stat = 1;
      8'hFF: begin m_idx = 0; m_wrap = 0; m_stat = 0; m_auto = 1; end
      default: ;
    endcase
    bus_wr(1'b0, 1'b1, {hi, c});
  endtask

  task automatic op_write(input logic [15:0] d, input logic [8:0] ua);
    wr_exp_t e;
    usr_addr = ua;
    e.addr = 9'(m_idx);
    e.data = d;
    e.old = m_mem[m_idx];
    e.chk_usr = (ua == 9'(m_idx));
    wr_q.push_back(e);
    m_mem[m_idx] = d;
    if (m_auto) model_advance();
    bus_wr(1'b0, 1'b0, d);
  endtask

  task automatic op_read();
    rd_exp_t e;
    if (m_stat) begin
      e.data = 16'((m_idx << 2) | (32'(m_wrap) << 1) | 32'(m_auto));
      m_stat = 0; m_wrap = 0;
    end else begin
      e.data = m_mem[m_idx];
      if (m_auto) model_advance();
    end
    e.idx = 9'(m_idx);
    rd_q.push_back(e);
    bus_rd();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_o"}, 32'(data_o), 32'd0);
    check({tag, "_index_o"}, 32'(index_o), 32'd0);
    check({tag, "_host_wr"}, 32'(host_wr), 32'd0);
    check({tag, "_host_wr_addr"}, 32'(host_wr_addr), 32'd0);
    check({tag, "_usr_rdata"}, 32'(usr_rdata), 32'd0);
  endtask

  // Read monitor: compares bus data and pointer at the end of each strobe
  initial begin : mon_rd
    rd_exp_t e;
    forever begin
      @(posedge noe);
      if (mon_rd_en && ncs === 1'b0) begin
        if (rd_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rd_unexpected actual=read_seen required=none at %0t", $time);
        end else begin
          e = rd_q.pop_front();
          check("rd_data_o", 32'(data_o), 32'(e.data));
          check("rd_index_o", 32'(index_o), 32'(e.idx));
        end
      end
    end
  end

  // Write monitor: host_wr strobe, its address, and read-before-write user port
  initial begin : mon_wr
    wr_exp_t e;
    bit pend;
    logic [15:0] pv;
    pend = 0;
    pv = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("usr_rdata_new", 32'(usr_rdata), 32'(pv));
        pend = 0;
      end
      if (host_wr === 1'b1) begin
        if (wr_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL host_wr_unexpected actual=pulse required=none at %0t", $time);
        end else begin
          e = wr_q.pop_front();
          check("host_wr_addr", 32'(host_wr_addr), 32'(e.addr));
          if (e.chk_usr) begin
            check("usr_rdata_old", 32'(usr_rdata), 32'(e.old));
            pend = 1;
            pv = e.data;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_l = 0; ncs = 1; noe = 1; nwe = 1; ale = 0; cle = 0;
    data_i = '0; usr_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("por");
    check("por_data_oe", 32'(data_oe), 32'd0);
    reset_l = 1;

    // Known contents everywhere before any directed or random traffic
    for (int i = 0; i < DEPTH; i++) op_write(16'(16'h8000 | i), 9'($urandom));
    op_cmd(8'hFF);

    // Address latch, two writes, readback with increment
    op_addr(16'h0010);
    op_write(16'hA5A5, 9'd0);
    op_write(16'h5A5A, 9'd0);
    op_addr(16'h0010);
    op_read();
    op_read();
    check("t1_index", 32'(index_o), 32'h012);
    check("t1_data", 32'(data_o), 32'h5A5A);

    // Increment off: repeated reads at one address
    op_addr(16'h0020);
    op_write(16'h1234, 9'd0);
    op_cmd(8'h01);
    op_addr(16'h0020);
    for (int i = 0; i < 3; i++) op_read();
    check("t2_index", 32'(index_o), 32'h020);
    check("t2_data", 32'(data_o), 32'h1234);
    op_cmd(8'h00);

    // Wrap at the top of memory and status reads
    op_addr(16'h01FF);
    op_write(16'hBEEF, 9'd0);
    check("t3_index_wrapped", 32'(index_o), 32'h000);
    op_cmd(8'h70);
    op_read();
    check("t3_status1", 32'(data_o), 32'h0003);
    op_cmd(8'h70);
    op_read();
    check("t3_status2", 32'(data_o), 32'h0001);

    // Strobes while deselected are ignored
    @(negedge clk);
    ncs = 1; data_i = 16'hDEAD; nwe = 0;
    repeat (3) @(negedge clk);
    nwe = 1;
    repeat (4) @(negedge clk);
    noe = 0;
    repeat (3) @(negedge clk);
    check("t4_data_oe_deselected", 32'(data_oe), 32'd0);
    noe = 1;
    repeat (5) @(negedge clk);
    check("t4_index", 32'(index_o), 32'h000);
    check("t4_data_o", 32'(data_o), 32'h0001);
    op_read();
    check("t4_mem0", 32'(data_o), 32'h8000);

    // Reset during a read strobe: nothing fires after release
    op_addr(16'h00AB);
    op_read();
    mon_rd_en = 0;
    @(negedge clk);
    ncs = 0; noe = 0;
    @(negedge clk);
    reset_l = 0;
    @(negedge clk);
    check_reset_values("midrd");
    reset_l = 1; noe = 1;
    model_reset();
    repeat (6) @(negedge clk);
    check("midrd_post_data_o", 32'(data_o), 32'd0);
    check("midrd_post_index", 32'(index_o), 32'd0);
    ncs = 1;
    @(negedge clk);
    mon_rd_en = 1;
    op_cmd(8'hFF);
    check("t5_index_after_ff", 32'(index_o), 32'd0);
    op_cmd(8'h70);
    op_read();
    check("t5_status", 32'(data_o), 32'h0001);

    // User port read-before-write on a host write to the same address
    op_addr(16'h0005);
    op_write(16'h0042, 9'd5);
    @(negedge clk);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      int unsigned k;
      k = $urandom_range(0, 9);
      if (k <= 2) begin
        op_write(16'($urandom),
                 ($urandom_range(0, 2) == 0) ? 9'(m_idx) : 9'($urandom));
      end else if (k <= 5) begin
        op_read();
      end else if (k <= 7) begin
        op_addr(($urandom_range(0, 3) == 0) ? 16'(16'h01FC + $urandom_range(0, 3))
                                            : 16'($urandom));
      end else begin
        case ($urandom_range(0, 5))
          0: op_cmd(8'h00);
          1: op_cmd(8'h01);
          2, 3: op_cmd(8'h70);
          4: op_cmd(8'hFF);
          default: op_cmd(8'($urandom_range(2, 16'h6F)));
        endcase
      end
    end

    repeat (10) @(negedge clk);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
